// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide beside the execute-stage ALU.
// 32-step shift-add multiply and restoring divide; stalls the pipe through Busy.
//
// state | meaning
// IDLE  | no operation; accepts StartE
// CALC  | iterating, step counter 0..31
// FIN   | Result valid, Done pulses
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StartE,
    input  logic [2:0]       FunctE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t             state, state_n;
    logic [5:0]         cnt;
    logic [2:0]         funct_q;
    logic               sign_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;

    logic               is_mul, a_signed, b_signed, a_neg, b_neg, res_sign;
    logic [WIDTH-1:0]   a_mag, b_mag, special_res;
    logic               div_zero, div_ovf, special, accept;

    logic [WIDTH:0]     add_sum, shifted, diff;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt, acc_nxt, mag, signed_res;
    logic [WIDTH-1:0]   final_res;

    // Operand conditioning at acceptance
    always_comb begin
        is_mul   = ~FunctE[2];
        a_signed = is_mul ? (FunctE[1:0] != 2'b11) : ~FunctE[0];
        b_signed = is_mul ? ~FunctE[1] : ~FunctE[0];
        a_neg    = a_signed & SrcAE[WIDTH-1];
        b_neg    = b_signed & SrcBE[WIDTH-1];
        a_mag    = a_neg ? -SrcAE : SrcAE;
        b_mag    = b_neg ? -SrcBE : SrcBE;
        // Remainder follows the dividend; products and quotients use the XOR
        res_sign = (~is_mul & FunctE[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = ~is_mul & (SrcBE == '0);
        div_ovf  = ~is_mul & ~FunctE[0] & (SrcAE == {1'b1, {(WIDTH-1){1'b0}}}) & (SrcBE == '1);
        special  = div_zero | div_ovf;
        if (div_zero)
            special_res = FunctE[1] ? SrcAE : '1;
        else
            special_res = FunctE[1] ? '0 : SrcAE;
        accept   = (state == IDLE) & StartE & ~FlushE;
    end

    // One iteration; multiplier/dividend lives in the low half of acc, opnd is
    // the multiplicand/divisor, the high half is accumulator/remainder.
    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_nxt = acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        shifted = acc[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, opnd};
        div_nxt = diff[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                              : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        acc_nxt = funct_q[2] ? div_nxt : mul_nxt;

        if (!funct_q[2])
            mag = acc_nxt;
        else if (funct_q[1])
            mag = {{WIDTH{1'b0}}, acc_nxt[2*WIDTH-1:WIDTH]};
        else
            mag = {{WIDTH{1'b0}}, acc_nxt[WIDTH-1:0]};
        signed_res = sign_q ? -mag : mag;
        final_res  = (~funct_q[2] & (funct_q[1:0] != 2'b00)) ? signed_res[2*WIDTH-1:WIDTH]
                                                             : signed_res[WIDTH-1:0];
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = special ? FIN : CALC;
            CALC: if (cnt == 6'd31) state_n = FIN;
            FIN:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (FlushE)
            state_n = IDLE;
        Busy = (accept | (state == CALC)) & ~rst;
        Done = (state == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            funct_q <= 3'd0;
            sign_q  <= 1'b0;
            acc     <= '0;
            opnd    <= '0;
            Result  <= '0;
        end else begin
            state <= state_n;
            cnt   <= ((state == CALC) && !FlushE) ? cnt + 6'd1 : 6'd0;
            if (accept) begin
                funct_q <= FunctE;
                sign_q  <= res_sign;
                acc     <= {{WIDTH{1'b0}}, a_mag};
                opnd    <= b_mag;
                if (special)
                    Result <= special_res;
            end
            if (state == CALC) begin
                acc <= acc_nxt;
                if ((cnt == 6'd31) && !FlushE)
                    Result <= final_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed RV32M vectors plus random operations,
// checked against an arithmetic reference model and cycle-exact timing.
module tb_muldiv_sequencer;

    logic        clk, rst, StartE, FlushE;
    logic [2:0]  FunctE;
    logic [31:0] SrcAE, SrcBE;
    logic        Busy, Done;
    logic [31:0] Result;

    int          ntests = 0;
    int          nfail  = 0;
    logic [31:0] last_res;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .StartE(StartE), .FunctE(FunctE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
        .Busy(Busy), .Done(Done), .Result(Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int          ia, ib;
        longint      sa, sb, ub;
        logic [63:0] ua64, ub64, p;
        ia = a; ib = b;
        sa = ia; sb = ib;
        ub = {32'h0, b};
        ua64 = {32'h0, a}; ub64 = {32'h0, b};
        case (f)
            3'd0: begin p = sa * sb;     return p[31:0];  end
            3'd1: begin p = sa * sb;     return p[63:32]; end
            3'd2: begin p = sa * ub;     return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f < 3'd4) return 1'b0;
        if (b == 0) return 1'b1;
        return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Called at a falling edge with the unit idle. keep=1 leaves StartE high
    // so the caller can issue the next instruction back to back.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit keep);
        logic [31:0] exp, res;
        int          lat, busy_n, done_at;
        exp     = model(f, a, b);
        lat     = is_special(f, a, b) ? 1 : 33;
        res     = 'x;
        busy_n  = 0;
        done_at = -1;
        StartE = 1'b1; FunctE = f; SrcAE = a; SrcBE = b;
        for (int k = 0; k <= 40 && done_at < 0; k++) begin
            #1;
            if (Busy === 1'b1) busy_n++;
            if (Done === 1'b1) begin
                done_at = k;
                res     = Result;
            end
            @(negedge clk);
            SrcAE  = $urandom;
            SrcBE  = $urandom;
            FunctE = 3'($urandom_range(7));
        end
        chk($sformatf("%s done_cycle", tag), done_at, lat);
        chk($sformatf("%s busy_cycles", tag), busy_n, lat);
        chk($sformatf("%s result", tag), res, exp);
        last_res = exp;
        if (!keep) begin
            StartE = 1'b0;
            #1;
            chk($sformatf("%s idle_done", tag), {31'b0, Done}, 32'd0);
            chk($sformatf("%s idle_busy", tag), {31'b0, Busy}, 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        int          done_seen;
        logic [2:0]  f;
        logic [31:0] a, b;
        int          mode;

        rst = 1'b1; StartE = 1'b0; FlushE = 1'b0; FunctE = 3'd0; SrcAE = 32'd0; SrcBE = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset busy", {31'b0, Busy}, 32'd0);
        chk("reset done", {31'b0, Done}, 32'd0);
        chk("reset result", Result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("mul_7_m3",    3'd0, 32'd7,          32'hFFFF_FFFD, 1'b0);
        run_op("mulh_min",    3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("mulhu_max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mulhsu_max",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9, 32'd2,         1'b0);
        run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'd2,         1'b0);
        run_op("divu_100_7",  3'd5, 32'd100,        32'd7,         1'b0);
        run_op("remu_100_7",  3'd7, 32'd100,        32'd7,         1'b0);
        run_op("div_5_0",     3'd4, 32'd5,          32'd0,         1'b0);
        run_op("remu_5_0",    3'd7, 32'd5,          32'd0,         1'b0);
        run_op("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // StartE held through FIN, then back-to-back instructions
        run_op("b2b_mul_a",   3'd0, 32'd1234,       32'd5678,      1'b1);
        run_op("b2b_mul_b",   3'd0, 32'hDEAD_BEEF, 32'd3,         1'b1);
        run_op("b2b_divu",    3'd5, 32'hFFFF_FFFF, 32'd10,        1'b0);

        // Flush while idle suppresses acceptance
        StartE = 1'b1; FlushE = 1'b1; FunctE = 3'd0; SrcAE = 32'd9; SrcBE = 32'd9;
        #1;
        chk("idle_flush busy", {31'b0, Busy}, 32'd0);
        @(negedge clk);
        StartE = 1'b0; FlushE = 1'b0;
        #1;
        chk("idle_flush not_accepted", {31'b0, Busy}, 32'd0);
        @(negedge clk);

        // Flush in the middle of CALC
        done_seen = 0;
        StartE = 1'b1; FunctE = 3'd0; SrcAE = $urandom; SrcBE = $urandom;
        for (int k = 0; k <= 10; k++) begin
            if (k == 10) FlushE = 1'b1;
            #1;
            if (Done === 1'b1) done_seen++;
            @(negedge clk);
        end
        FlushE = 1'b0; StartE = 1'b0;
        #1;
        chk("flush busy", {31'b0, Busy}, 32'd0);
        chk("flush done", {31'b0, Done}, 32'd0);
        chk("flush result_kept", Result, last_res);
        chk("flush no_done_before", done_seen, 32'd0);
        @(negedge clk);
        run_op("after_flush_mul_3_4", 3'd0, 32'd3, 32'd4, 1'b0);

        // Reset in the middle of an operation
        StartE = 1'b1; FunctE = 3'd5; SrcAE = $urandom; SrcBE = $urandom | 32'd1;
        for (int k = 0; k < 20; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst busy_during", {31'b0, Busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0; StartE = 1'b0;
        #1;
        chk("rst busy_after", {31'b0, Busy}, 32'd0);
        chk("rst done_after", {31'b0, Done}, 32'd0);
        chk("rst result_after", Result, 32'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (Done === 1'b1) done_seen++;
        end
        chk("rst no_done_later", done_seen, 32'd0);
        @(negedge clk);

        // Random operations, including zero divisors and signed overflow
        for (int i = 0; i < 30; i++) begin
            f    = 3'($urandom_range(7));
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(5);
            if (mode == 0) b = 32'd0;
            else if (mode == 1) b = 32'($urandom_range(15));
            else if (mode == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, (i != 29) && ($urandom_range(1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative RV32M multiply/divide unit that sits beside the ALU in the execute stage of the pipelined core. It latches operands when an M-extension instruction reaches execute, runs a 32-step shift-add multiply or restoring divide, and raises `Busy` so the hazard unit holds fetch, decode and execute. When the result is ready it pulses `Done` with the result for the execute/memory pipeline register. Killing the occupying instruction with `FlushE` aborts the operation.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is supported.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `StartE` input 1: execute-stage instruction is M-extension; held high while the instruction sits in execute.
- `FunctE` input 3: RV32M funct3. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `SrcAE` input 32: rs1 value after forwarding.
- `SrcBE` input 32: rs2 value after forwarding.
- `FlushE` input 1: execute-stage instruction is being killed.
- `Busy` output 1: stall request to the hazard unit.
- `Done` output 1: one-cycle pulse; `Result` is valid in this cycle.
- `Result` output 32: registered result. Held until the next `Done`.

## Operation
- **States**
  - IDLE: no operation in progress.
  - CALC: iterating; internal 6-bit step counter runs 0..31.
  - FIN: result ready; `Done`=1.
- **IDLE with StartE=1 and FlushE=0**
  - Latch `FunctE`.
  - Latch |SrcAE| and |SrcBE| per signedness.
    - MUL, MULH, DIV and REM treat both operands as signed.
    - MULHSU treats rs1 as signed and rs2 as unsigned.
    - MULHU, DIVU and REMU treat both operands as unsigned.
  - Record the result sign.
    - Products: sign = XOR of the operand signs.
    - Quotient: sign = XOR of the operand signs.
    - Remainder: sign = dividend sign.
  - Go to CALC, or go straight to FIN for a special case.
- **Special cases (IDLE→FIN, no CALC)**
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give SrcAE.
  - Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM of the same operands gives 0.
- **Multiply**
  - Each CALC step: if multiplier LSB=1, add the multiplicand to the upper half of a 64-bit accumulator; then shift right by 1, with the carry-out entering bit 63.
  - After 32 steps, negate the 64-bit magnitude if the sign is set.
  - MUL takes the low 32 bits; the MULH variants take the high 32 bits.
- **Divide (restoring)**
  - Each step: shift {rem, quot} left by 1, then trial-subtract the divisor from the 33-bit remainder.
  - If the result is non-negative, keep it and set quot[0]=1.
  - After 32 steps, apply the quotient and remainder signs by two's-complement negation.
- **CALC→FIN** after step 31. `Result` is written on that edge.
- **FIN→IDLE** unconditionally. `StartE` during FIN is ignored, because it is the same instruction leaving execute.
- **Busy** = ((state==IDLE & StartE & ~FlushE) | state==CALC) & ~rst. It is 0 in FIN.
- **FlushE=1 in any state**
  - Next state is IDLE; the step counter clears.
  - `Done` stays 0 on the following cycle and `Result` is unchanged.
  - In IDLE it also suppresses acceptance of StartE.
- **Reset values**
  - state = IDLE, counter = 0.
  - `Result` = 0, `Done` = 0, `Busy` = 0.
  - Reset overrides an operation in progress; no `Done` follows.

## Timing
- StartE is accepted at the end of cycle c.
  - Normal operation:
    - CALC occupies cycles c+1..c+32.
    - FIN is cycle c+33.
    - `Busy`=1 in cycles c..c+32 (33 cycles).
    - `Done`=1 only in c+33.
    - Total occupancy of execute is 34 cycles.
  - Special case: `Busy`=1 in c, `Done`=1 in c+1, total occupancy 2 cycles.
- Operands are sampled only at acceptance. Forwarded values changing during CALC are ignored.
- Back-to-back M-instructions: the second instruction enters execute at c+34, which is IDLE, and is accepted the same cycle.
- `Result` is a register, with no combinational path from the inputs. `Busy` is combinational from StartE, FlushE and state.

## Test plan
- **MUL 7 × 0xFFFFFFFD (−3)**: `Busy` high 33 cycles, then `Done` in c+33 with `Result`=0xFFFFFFEB.
- **MULH and MULHU**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Divide**
  - DIV −7 / 2 → 0xFFFFFFFD.
  - REM −7 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
  - Each result appears at c+33.
- **Special cases** (`Done` at c+1, `Busy` 1 cycle)
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- **FlushE mid-CALC**: pulse FlushE at c+10 → IDLE at c+11, no `Done` ever, `Result` keeps its prior value. An immediate new MUL 3 × 4 → 12 at its own c+33.
- **Reset mid-operation**: assert `rst` at c+20 → `Busy`=0, `Done`=0, `Result`=0 next cycle, no `Done` afterwards. `StartE` held in FIN is not re-accepted; back-to-back MULs each give exactly one `Done`.
